// File: rtl/demle_zamanlayici.sv
// Brew countdown timer: takes one brew result per bitti rising edge,
// counts it down in TIK_BOLEN-cycle units and waits for the cup to be taken.
module demle_zamanlayici #(
    parameter int TIK_BOLEN = 100
) (
    input  logic        saat,
    input  logic        reset,
    input  logic        bitti,
    input  logic        demlendi,
    input  logic [14:0] sure,
    input  logic        al,
    input  logic        iptal,
    output logic        mesgul,
    output logic        demleniyor,
    output logic        hazir,
    output logic        hata,
    output logic        alarm,
    output logic [14:0] kalan_sure,
    output logic        bekleyen,
    output logic        tasma
);

    localparam int PW = (TIK_BOLEN > 2) ? $clog2(TIK_BOLEN) : 1;
    localparam logic [PW-1:0] SON = PW'(TIK_BOLEN - 1);

    typedef enum logic [1:0] {
        BOSTA      = 2'd0,
        DEMLENIYOR = 2'd1,
        HAZIR      = 2'd2,
        HATA       = 2'd3
    } durum_t;

    durum_t        st, st_n;
    logic [14:0]   kalan, kalan_n;
    logic [PW-1:0] presc, presc_n;
    logic          bitti_q;
    logic          slot_v, slot_v_n;
    logic          slot_d, slot_d_n;
    logic [14:0]   slot_s, slot_s_n;
    logic          tasma_q, tasma_n;
    logic          alarm_q, alarm_n;

    logic          job;
    logic          launch;
    logic          store;
    logic          l_d;
    logic [14:0]   l_s;

    assign job = bitti & ~bitti_q;

    always_ff @(posedge saat) begin
        if (!reset) begin
            st      <= BOSTA;
            kalan   <= '0;
            presc   <= '0;
            bitti_q <= 1'b0;
            slot_v  <= 1'b0;
            slot_d  <= 1'b0;
            slot_s  <= '0;
            tasma_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            st      <= st_n;
            kalan   <= kalan_n;
            presc   <= presc_n;
            bitti_q <= bitti;
            slot_v  <= slot_v_n;
            slot_d  <= slot_d_n;
            slot_s  <= slot_s_n;
            tasma_q <= tasma_n;
            alarm_q <= alarm_n;
        end
    end

    always_comb begin
        st_n     = st;
        kalan_n  = kalan;
        presc_n  = presc;
        slot_v_n = slot_v;
        slot_d_n = slot_d;
        slot_s_n = slot_s;
        tasma_n  = tasma_q;
        alarm_n  = 1'b0;
        launch   = 1'b0;
        store    = 1'b0;
        l_d      = demlendi;
        l_s      = sure;

        if (iptal) begin
            st_n     = BOSTA;
            kalan_n  = '0;
            presc_n  = '0;
            slot_v_n = 1'b0;
        end else begin
            case (st)
                BOSTA: launch = job;
                DEMLENIYOR: begin
                    store = job;
                    if (presc == SON) begin
                        presc_n = '0;
                        if (kalan != 15'd0)
                            kalan_n = kalan - 15'd1;
                        if (kalan == 15'd1) begin
                            st_n    = HAZIR;
                            alarm_n = 1'b1;
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                HAZIR, HATA: begin
                    if (al) begin
                        if (slot_v) begin
                            // pending job goes first, a fresh one refills the slot
                            launch   = 1'b1;
                            l_d      = slot_d;
                            l_s      = slot_s;
                            slot_v_n = 1'b0;
                            store    = job;
                        end else if (job) begin
                            launch = 1'b1;
                        end else begin
                            st_n = BOSTA;
                        end
                    end else begin
                        store = job;
                    end
                end
                default: st_n = BOSTA;
            endcase

            if (store) begin
                if (!slot_v_n) begin
                    slot_v_n = 1'b1;
                    slot_d_n = demlendi;
                    slot_s_n = sure;
                end else begin
                    tasma_n = 1'b1;
                end
            end

            if (launch) begin
                presc_n = '0;
                if (!l_d) begin
                    st_n    = HATA;
                    kalan_n = '0;
                end else if (l_s == 15'd0) begin
                    st_n    = HAZIR;
                    kalan_n = '0;
                    alarm_n = 1'b1;
                end else begin
                    st_n    = DEMLENIYOR;
                    kalan_n = l_s;
                end
            end
        end
    end

    assign mesgul     = (st != BOSTA);
    assign demleniyor = (st == DEMLENIYOR);
    assign hazir      = (st == HAZIR);
    assign hata       = (st == HATA);
    assign alarm      = alarm_q;
    assign kalan_sure = kalan;
    assign bekleyen   = slot_v;
    assign tasma      = tasma_q;

endmodule

// File: tb/tb_demle_zamanlayici.sv
// Directed bench for demle_zamanlayici with TIK_BOLEN=4.
// Outputs packed as {mesgul,dem,hazir,hata,alarm,bekleyen,tasma,kalan[14:0]}.
module tb_demle_zamanlayici;

    localparam int TB = 4;

    logic        saat = 1'b0;
    logic        reset;
    logic        bitti;
    logic        demlendi;
    logic [14:0] sure;
    logic        al;
    logic        iptal;
    logic        mesgul;
    logic        demleniyor;
    logic        hazir;
    logic        hata;
    logic        alarm;
    logic [14:0] kalan_sure;
    logic        bekleyen;
    logic        tasma;

    int checks = 0;
    int failures = 0;

    demle_zamanlayici #(.TIK_BOLEN(TB)) dut (
        .saat(saat), .reset(reset), .bitti(bitti), .demlendi(demlendi),
        .sure(sure), .al(al), .iptal(iptal), .mesgul(mesgul),
        .demleniyor(demleniyor), .hazir(hazir), .hata(hata),
        .alarm(alarm), .kalan_sure(kalan_sure), .bekleyen(bekleyen),
        .tasma(tasma)
    );

    always #5 saat = ~saat;

    typedef struct {
        logic        b;
        logic        d;
        logic [14:0] s;
        logic        a;
        logic        i;
        int          rep;
        logic [21:0] exp;
    } vek_t;

    function automatic logic [21:0] mk(logic m, logic dm, logic hz, logic ht,
                                       logic alm, logic bk, logic ts,
                                       logic [14:0] k);
        return {m, dm, hz, ht, alm, bk, ts, k};
    endfunction

    function automatic logic [21:0] cur();
        return {mesgul, demleniyor, hazir, hata, alarm, bekleyen, tasma,
                kalan_sure};
    endfunction

    task automatic step();
        @(posedge saat);
        #1;
    endtask

    task automatic chk(string nm, logic [21:0] exp);
        checks++;
        if (cur() !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (m,dm,hz,ht,alm,bk,ts,kalan)",
                     nm, cur(), exp);
        end
    endtask

    task automatic drive(logic b, logic d, logic [14:0] s, logic a, logic i);
        bitti = b; demlendi = d; sure = s; al = a; iptal = i;
    endtask

    vek_t tab[$];

    initial begin
        int n;
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        step();
        chk("reset", mk(0,0,0,0,0,0,0,15'd0));
        reset = 1'b1;

        // basic countdown sure=3
        tab.push_back('{1,1,15'd3,0,0,1,mk(1,1,0,0,0,0,0,15'd3)});
        tab.push_back('{0,0,15'd0,0,0,3,mk(1,1,0,0,0,0,0,15'd3)});
        tab.push_back('{0,0,15'd0,0,0,1,mk(1,1,0,0,0,0,0,15'd2)});
        tab.push_back('{0,0,15'd0,0,0,3,mk(1,1,0,0,0,0,0,15'd2)});
        tab.push_back('{0,0,15'd0,0,0,1,mk(1,1,0,0,0,0,0,15'd1)});
        tab.push_back('{0,0,15'd0,0,0,3,mk(1,1,0,0,0,0,0,15'd1)});
        tab.push_back('{0,0,15'd0,0,0,1,mk(1,0,1,0,1,0,0,15'd0)});
        tab.push_back('{0,0,15'd0,0,0,1,mk(1,0,1,0,0,0,0,15'd0)});
        tab.push_back('{0,0,15'd0,1,0,1,mk(0,0,0,0,0,0,0,15'd0)});
        // error path, bitti held high
        tab.push_back('{1,0,15'd0,0,0,1,mk(1,0,0,1,0,0,0,15'd0)});
        tab.push_back('{1,0,15'd0,0,0,9,mk(1,0,0,1,0,0,0,15'd0)});
        tab.push_back('{1,0,15'd0,1,0,1,mk(0,0,0,0,0,0,0,15'd0)});
        tab.push_back('{1,0,15'd0,0,0,2,mk(0,0,0,0,0,0,0,15'd0)});
        tab.push_back('{0,0,15'd0,0,0,1,mk(0,0,0,0,0,0,0,15'd0)});
        // zero duration
        tab.push_back('{1,1,15'd0,0,0,1,mk(1,0,1,0,1,0,0,15'd0)});
        tab.push_back('{0,0,15'd0,0,0,1,mk(1,0,1,0,0,0,0,15'd0)});
        tab.push_back('{0,0,15'd0,1,0,1,mk(0,0,0,0,0,0,0,15'd0)});
        // al ignored while idle
        tab.push_back('{0,0,15'd0,1,0,2,mk(0,0,0,0,0,0,0,15'd0)});

        foreach (tab[k]) begin
            drive(tab[k].b, tab[k].d, tab[k].s, tab[k].a, tab[k].i);
            for (int r = 0; r < tab[k].rep; r++) begin
                step();
                chk($sformatf("vec%0d.%0d", k, r), tab[k].exp);
            end
        end
        drive(0, 0, 0, 0, 0);
        step();

        // pending job and overflow
        drive(1, 1, 15'd5, 0, 0); step();
        chk("pend_start", mk(1,1,0,0,0,0,0,15'd5));
        drive(0, 0, 0, 0, 0); step();
        drive(1, 1, 15'd2, 0, 0); step();
        chk("pend_store", mk(1,1,0,0,0,1,0,15'd5));
        drive(0, 0, 0, 0, 0); step();
        drive(1, 1, 15'd7, 0, 0); step();
        chk("pend_ovf", mk(1,1,0,0,0,1,1,15'd4));
        drive(0, 0, 0, 0, 0);
        n = 0;
        while (!hazir && n < 100) begin step(); n++; end
        chk("pend_hazir", mk(1,0,1,0,1,1,1,15'd0));
        drive(0, 0, 0, 1, 0); step();
        chk("pend_launch", mk(1,1,0,0,0,0,1,15'd2));
        drive(0, 0, 0, 0, 0);
        for (int r = 0; r < 7; r++) step();
        chk("pend_pre", mk(1,1,0,0,0,0,1,15'd1));
        step();
        chk("pend_done", mk(1,0,1,0,1,0,1,15'd0));
        drive(0, 0, 0, 1, 0); step();
        chk("pend_idle", mk(0,0,0,0,0,0,1,15'd0));

        // cancel mid-brew with a pending job and a coinciding job
        drive(1, 1, 15'd100, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        drive(1, 1, 15'd3, 0, 0); step();
        chk("cancel_pend", mk(1,1,0,0,0,1,1,15'd100));
        drive(0, 0, 0, 0, 0); step();
        drive(1, 1, 15'd4, 0, 1); step();
        chk("cancel", mk(0,0,0,0,0,0,1,15'd0));
        drive(1, 1, 15'd4, 0, 0); step();
        chk("cancel_edge", mk(0,0,0,0,0,0,1,15'd0));
        drive(0, 0, 0, 0, 0); step();

        // reset mid-brew clears tasma too
        drive(1, 1, 15'd9, 0, 0); step();
        chk("rst_pre", mk(1,1,0,0,0,0,1,15'd9));
        drive(0, 0, 0, 0, 0);
        reset = 1'b0; step();
        chk("rst_mid", mk(0,0,0,0,0,0,0,15'd0));
        reset = 1'b1; step();

        // long brew, sure=705
        drive(1, 1, 15'd705, 0, 0); step();
        chk("long_start", mk(1,1,0,0,0,0,0,15'd705));
        drive(0, 0, 0, 0, 0);
        n = 0;
        while (!hazir && n < 705 * TB + 20) begin step(); n++; end
        checks++;
        if (n != 705 * TB) begin
            failures++;
            $display("FAIL long_latency: got %0d want %0d", n, 705 * TB);
        end
        chk("long_hazir", mk(1,0,1,0,1,0,0,15'd0));
        drive(0, 0, 0, 1, 0); step();
        chk("long_idle", mk(0,0,0,0,0,0,0,15'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
